jt5205_feeder: RTL and testbench

ROM-side sample streamer for the JT5205 ADPCM path; it is the consumer end of the sample-rate strobe.
- On each qualified sample strobe (vck, the cen_lo output of the timing block), it supplies the next 4-bit ADPCM nibble on din.
- It fetches bytes from sample ROM through a cs/ok handshake and keeps a two-byte pipeline (current byte plus one prefetch byte).
- It holds the decoder in reset while idle.
- Sits between the sound CPU's start/address latches and jt5205's din/rst pins.

---
 rtl/jt5205_pkg.sv | 16 +
 rtl/jt5205_feeder_buf.sv | 102 ++++++++++
 rtl/jt5205_feeder.sv | 165 ++++++++++++++++
 tb/tb_jt5205_feeder.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt5205_pkg.sv
// Shared types and constants for the jt5205 ROM sample feeder.
// Latency: none (declarations only).
// Backpressure: n/a.
package jt5205_pkg;

    localparam int         AW_DEFAULT     = 16;
    localparam logic [3:0] SILENCE_NIBBLE = 4'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        PLAY  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/jt5205_feeder_buf.sv
// Two-byte sample pipeline (current byte + one prefetch byte) with high/low nibble select.
// Latency: pop_req to registered state 1 clk; nibble_o is combinational for the caller's din register.
// Backpressure: need_fetch_o requests a byte while the prefetch slot is free; underflow_o flags a low-nibble pop with nothing to refill.
module jt5205_feeder_buf
    import jt5205_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       push_i,
    input  logic [7:0] push_dat_i,
    input  logic       push_last_i,
    input  logic       pop_req_i,
    output logic [3:0] nibble_o,
    output logic       need_fetch_o,
    output logic       empty_o,
    output logic       underflow_o,
    output logic       cur_load_o,
    output logic       load_last_o
);

    logic [7:0] cur_q, cur_d, buf_q, buf_d;
    logic       cur_valid_q, cur_valid_d, buf_valid_q, buf_valid_d;
    logic       buf_last_q, buf_last_d, phase_q, phase_d;
    logic       pop_lo;

    assign pop_lo       = pop_req_i & phase_q;
    assign need_fetch_o = ~buf_valid_q;
    assign empty_o      = ~cur_valid_q & ~buf_valid_q;

    always_comb begin
        cur_d       = cur_q;
        buf_d       = buf_q;
        cur_valid_d = cur_valid_q;
        buf_valid_d = buf_valid_q;
        buf_last_d  = buf_last_q;
        phase_d     = phase_q;
        nibble_o    = cur_q[7:4];
        underflow_o = 1'b0;
        cur_load_o  = 1'b0;
        load_last_o = 1'b0;
        if (clear_i) begin
            cur_valid_d = 1'b0;
            buf_valid_d = 1'b0;
            buf_last_d  = 1'b0;
            phase_d     = 1'b0;
        end else begin
            if (pop_req_i && !phase_q) begin
                // With no byte in hand the high-nibble slot plays silence and waits.
                if (cur_valid_q) phase_d = 1'b1;
                else             nibble_o = SILENCE_NIBBLE;
            end else if (pop_lo) begin
                nibble_o = cur_q[3:0];
                phase_d  = 1'b0;
                if (buf_valid_q) begin
                    cur_d       = buf_q;
                    buf_valid_d = 1'b0;
                    cur_load_o  = 1'b1;
                    load_last_o = buf_last_q;
                end else if (push_i) begin
                    cur_d       = push_dat_i;
                    cur_load_o  = 1'b1;
                    load_last_o = push_last_i;
                end else begin
                    cur_valid_d = 1'b0;
                    underflow_o = 1'b1;
                end
            end
            if (push_i && !pop_lo) begin
                if (!cur_valid_q) begin
                    cur_d       = push_dat_i;
                    cur_valid_d = 1'b1;
                    cur_load_o  = 1'b1;
                    load_last_o = push_last_i;
                end else begin
                    buf_d       = push_dat_i;
                    buf_valid_d = 1'b1;
                    buf_last_d  = push_last_i;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q       <= 8'd0;
            buf_q       <= 8'd0;
            cur_valid_q <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_last_q  <= 1'b0;
            phase_q     <= 1'b0;
        end else begin
            cur_q       <= cur_d;
            buf_q       <= buf_d;
            cur_valid_q <= cur_valid_d;
            buf_valid_q <= buf_valid_d;
            buf_last_q  <= buf_last_d;
            phase_q     <= phase_d;
        end
    end

endmodule

// File: rtl/jt5205_feeder.sv
// ROM-side ADPCM nibble streamer for jt5205; JT5205_FEEDER_LOOP_EN makes playback loop start..end until rst.
// Latency: start->rom_cs 1 clk, rom_ok->adpcm_rst low 1 clk, vck->din 1 clk.
// Backpressure: ROM stalls through rom_cs/rom_ok; a byte missing at a low-nibble vck sets sticky underrun.
module jt5205_feeder
    import jt5205_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vck,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    output logic [3:0]    din,
    output logic          adpcm_rst,
    output logic          busy,
    output logic          done,
    output logic          underrun
);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d, first_q, first_d, stop_q, stop_d;
    logic          cs_q, cs_d, busy_q, busy_d, done_q, done_d;
    logic          arst_q, arst_d, urun_q, urun_d, last_q, last_d;
    logic [3:0]    din_q, din_d;
    logic          fetch_hit, hit_end, push, pop_req;
    logic [3:0]    nibble;
    logic          need_fetch, empty, underflow, cur_load, load_last;

    assign fetch_hit = cs_q & rom_ok;
    assign hit_end   = (addr_q == stop_q);
    assign push      = fetch_hit & ~start;
    assign pop_req   = vck & ~start & ((state_q == PLAY) | (state_q == DRAIN));

    jt5205_feeder_buf u_buf (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (start),
        .push_i       (push),
        .push_dat_i   (rom_data),
        .push_last_i  (hit_end),
        .pop_req_i    (pop_req),
        .nibble_o     (nibble),
        .need_fetch_o (need_fetch),
        .empty_o      (empty),
        .underflow_o  (underflow),
        .cur_load_o   (cur_load),
        .load_last_o  (load_last)
    );

`ifndef JT5205_FEEDER_LOOP_EN
    logic loop_unused;
    assign loop_unused = cur_load & load_last;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        first_d = first_q;
        stop_d  = stop_q;
        cs_d    = cs_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        arst_d  = arst_q;
        urun_d  = urun_q;
        last_d  = last_q;
        din_d   = din_q;
        if (start) begin
            first_d = start_addr;
            stop_d  = end_addr;
            addr_d  = start_addr;
            cs_d    = 1'b1;
            busy_d  = 1'b1;
            arst_d  = 1'b1;
            urun_d  = 1'b0;
            last_d  = 1'b0;
            state_d = LOAD;
        end else begin
            if (pop_req) din_d = nibble;
            if (underflow && !last_q) urun_d = 1'b1;
            if (fetch_hit) begin
                cs_d = 1'b0;
`ifdef JT5205_FEEDER_LOOP_EN
                addr_d = hit_end ? first_q : addr_q + AW'(1);
`else
                addr_d = addr_q + AW'(1);
                if (hit_end) last_d = 1'b1;
`endif
            end else if (state_q == PLAY && !cs_q && need_fetch && !last_q) begin
                cs_d = 1'b1;
            end
`ifdef JT5205_FEEDER_LOOP_EN
            done_d = cur_load & load_last;
`endif
            case (state_q)
                LOAD: begin
                    if (fetch_hit) begin
                        arst_d  = 1'b0;
                        state_d = PLAY;
`ifndef JT5205_FEEDER_LOOP_EN
                        if (hit_end) state_d = DRAIN;
`endif
                    end
                end
                PLAY: begin
`ifndef JT5205_FEEDER_LOOP_EN
                    // Last byte fetched and prefetch slot empty: that byte is now playing.
                    if (last_q && need_fetch) state_d = DRAIN;
`endif
                end
                DRAIN: begin
                    if (empty) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        arst_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            first_q <= '0;
            stop_q  <= '0;
            cs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            arst_q  <= 1'b1;
            urun_q  <= 1'b0;
            last_q  <= 1'b0;
            din_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            first_q <= first_d;
            stop_q  <= stop_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            arst_q  <= arst_d;
            urun_q  <= urun_d;
            last_q  <= last_d;
            din_q   <= din_d;
        end
    end

    assign rom_addr  = addr_q;
    assign rom_cs    = cs_q;
    assign din       = din_q;
    assign adpcm_rst = arst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign underrun  = urun_q;

endmodule

// File: tb/tb_jt5205_feeder.sv
// Bench for jt5205_feeder (one-shot build): ROM responder, fetch/done monitor and a nibble-stream model
// built straight from the address range and ROM contents.
module tb_jt5205_feeder;

    logic        clk, rst, vck, start;
    logic [15:0] start_addr, end_addr, rom_addr;
    logic        rom_cs, rom_ok, adpcm_rst, busy, done, underrun;
    logic [7:0]  rom_data;
    logic [3:0]  din;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [65536];
    logic [15:0] fetch_q [$];
    logic [15:0] exp_req [$];
    logic [3:0]  exp_nib [$];
    logic [3:0]  got [$];
    logic [3:0]  last_nib = 4'd0;
    int          done_cnt = 0;
    int          cs_cnt = 0;
    int          lat = 2;
    bit          manual = 1'b0;
    logic        man_ok = 1'b0;
    logic [7:0]  man_dat = 8'd0;

    jt5205_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .vck        (vck),
        .start      (start),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .rom_addr   (rom_addr),
        .rom_cs     (rom_cs),
        .rom_data   (rom_data),
        .rom_ok     (rom_ok),
        .din        (din),
        .adpcm_rst  (adpcm_rst),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM responder: answers lat cycles after a request appears, with data for the address shown.
    initial begin
        int          cnt;
        logic [16:0] caddr;
        cnt = 0;
        caddr = '1;
        rom_ok = 1'b0;
        rom_data = 8'd0;
        forever begin
            @(posedge clk);
            #1;
            if (manual) begin
                rom_ok = man_ok;
                rom_data = man_dat;
                cnt = 0;
            end else if (rom_ok) begin
                rom_ok = 1'b0;
                cnt = 0;
                caddr = '1;
            end else if (rom_cs) begin
                if ({1'b0, rom_addr} !== caddr) begin
                    cnt = 0;
                    caddr = {1'b0, rom_addr};
                end
                cnt++;
                if (cnt >= lat) begin
                    rom_ok = 1'b1;
                    rom_data = mem[rom_addr];
                    cnt = 0;
                    caddr = '1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rom_cs && rom_ok) fetch_q.push_back(rom_addr);
            if (done) done_cnt++;
            if (rom_cs) cs_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [15:0] sa, input logic [15:0] ea);
        logic [15:0] a;
        start_addr = sa;
        end_addr = ea;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        fetch_q.delete();
        exp_req.delete();
        exp_nib.delete();
        a = sa;
        forever begin
            exp_req.push_back(a);
            exp_nib.push_back(mem[a][7:4]);
            exp_nib.push_back(mem[a][3:0]);
            if (a == ea) break;
            a = a + 16'd1;
        end
        checks++;
        if (rom_cs !== 1'b1 || rom_addr !== sa || busy !== 1'b1 || adpcm_rst !== 1'b1 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL start_response: cs=%b addr=%h busy=%b arst=%b urun=%b, required cs=1 addr=%h busy=1 arst=1 urun=0",
                     rom_cs, rom_addr, busy, adpcm_rst, underrun, sa);
        end
    endtask

    task automatic play_out(input int per, output bit ok);
        int d0;
        ok = 1'b1;
        for (int i = 0; i < 2000 && adpcm_rst; i++) tick(1);
        if (adpcm_rst) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: adpcm_rst still %b after 2000 clk, required 0", adpcm_rst);
            ok = 1'b0;
            return;
        end
        got.delete();
        d0 = done_cnt;
        for (int i = 0; i < exp_nib.size() + 40 && done_cnt == d0; i++) begin
            vck = 1'b1;
            tick(1);
            vck = 1'b0;
            got.push_back(din);
            tick(per - 1);
        end
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done after %0d vck, required a done pulse", got.size());
            ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vck = 1'b0;
        start = 1'b0;
        start_addr = 16'd0;
        end_addr = 16'd0;
        tick(3);
        checks++; if (rom_cs !== 1'b0)    begin errors++; $display("FAIL reset_cs: got %b required 0", rom_cs); end
        checks++; if (rom_addr !== 16'd0) begin errors++; $display("FAIL reset_addr: got %h required 0000", rom_addr); end
        checks++; if (din !== 4'd0)       begin errors++; $display("FAIL reset_din: got %h required 0", din); end
        checks++; if (adpcm_rst !== 1'b1) begin errors++; $display("FAIL reset_arst: got %b required 1", adpcm_rst); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b required 0", done); end
        checks++; if (underrun !== 1'b0)  begin errors++; $display("FAIL reset_underrun: got %b required 0", underrun); end
        rst = 1'b0;
        tick(2);
        vck = 1'b1;
        tick(1);
        vck = 1'b0;
        tick(1);
        checks++;
        if (din !== 4'd0 || busy !== 1'b0 || rom_cs !== 1'b0) begin
            errors++;
            $display("FAIL idle_vck: din=%h busy=%b cs=%b, required din=0 busy=0 cs=0", din, busy, rom_cs);
        end
    endtask

    task automatic test_playback(input string name, input logic [15:0] sa, input logic [15:0] ea,
                                 input int l, input int per);
        int d0;
        bit ok, bad;
        d0 = done_cnt;
        lat = l;
        kick(sa, ea);
        play_out(per, ok);
        tick(2);
        if (!ok) return;
        bad = (got.size() != exp_nib.size());
        if (!bad) foreach (exp_nib[i]) if (got[i] !== exp_nib[i]) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s_nibbles: got %0d nibbles starting %h, required %0d starting %h",
                     name, got.size(), got.size() > 0 ? got[0] : 4'hx, exp_nib.size(), exp_nib[0]);
        end
        bad = (fetch_q.size() != exp_req.size());
        if (!bad) foreach (exp_req[i]) if (fetch_q[i] !== exp_req[i]) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s_fetches: got %0d fetches starting %h, required %0d starting %h",
                     name, fetch_q.size(), fetch_q.size() > 0 ? fetch_q[0] : 16'hxxxx, exp_req.size(), exp_req[0]);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL %s_done: got %0d done cycles, required 1", name, done_cnt - d0);
        end
        checks++;
        if (underrun !== 1'b0 || busy !== 1'b0 || adpcm_rst !== 1'b1 || din !== exp_nib[exp_nib.size()-1]) begin
            errors++;
            $display("FAIL %s_end_state: urun=%b busy=%b arst=%b din=%h, required urun=0 busy=0 arst=1 din=%h",
                     name, underrun, busy, adpcm_rst, din, exp_nib[exp_nib.size()-1]);
        end
        last_nib = exp_nib[exp_nib.size()-1];
    endtask

    task automatic test_basic();
        mem[16'h0100] = 8'h12;
        mem[16'h0101] = 8'h34;
        test_playback("basic", 16'h0100, 16'h0101, 2, 40);
    endtask

    task automatic test_bypass();
        logic [7:0] b0, b1;
        int d0;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        d0 = done_cnt;
        manual = 1'b1;
        kick(16'h0300, 16'h0301);
        @(negedge clk);
        man_ok = 1'b1;
        man_dat = b0;
        @(negedge clk);
        man_ok = 1'b0;
        checks++;
        if (adpcm_rst !== 1'b1) begin errors++; $display("FAIL bypass_arst_before_ok: got %b required 1", adpcm_rst); end
        tick(1);
        checks++;
        if (adpcm_rst !== 1'b0) begin errors++; $display("FAIL bypass_arst_after_ok: got %b required 0", adpcm_rst); end
        tick(2);
        vck = 1'b1;
        tick(1);
        vck = 1'b0;
        checks++;
        if (din !== b0[7:4]) begin errors++; $display("FAIL bypass_hi0: got %h required %h", din, b0[7:4]); end
        @(negedge clk);
        man_ok = 1'b1;
        man_dat = b1;
        @(posedge clk);
        #1;
        vck = 1'b1;
        @(negedge clk);
        man_ok = 1'b0;
        @(posedge clk);
        #1;
        vck = 1'b0;
        checks++;
        if (din !== b0[3:0] || underrun !== 1'b0) begin
            errors++;
            $display("FAIL bypass_lo0: din=%h urun=%b, required din=%h urun=0", din, underrun, b0[3:0]);
        end
        tick(3);
        vck = 1'b1;
        tick(1);
        vck = 1'b0;
        checks++;
        if (din !== b1[7:4]) begin errors++; $display("FAIL bypass_hi1: got %h required %h", din, b1[7:4]); end
        tick(3);
        vck = 1'b1;
        tick(1);
        vck = 1'b0;
        tick(3);
        checks++;
        if (din !== b1[3:0] || underrun !== 1'b0 || done_cnt - d0 != 1 || fetch_q.size() != 2) begin
            errors++;
            $display("FAIL bypass_end: din=%h urun=%b done=%0d fetches=%0d, required din=%h urun=0 done=1 fetches=2",
                     din, underrun, done_cnt - d0, fetch_q.size(), b1[3:0]);
        end
        manual = 1'b0;
        last_nib = b1[3:0];
    endtask

    task automatic test_underrun();
        logic [15:0] sa;
        int d0, n;
        bit ok, bad;
        sa = 16'($urandom_range(16'h1000, 16'hEFFF));
        mem[sa] = 8'hAB;
        mem[sa + 16'd1] = 8'hCD;
        d0 = done_cnt;
        lat = 100;
        kick(sa, sa + 16'd1);
        tick(3);
        vck = 1'b1;
        tick(1);
        vck = 1'b0;
        checks++;
        if (din !== last_nib || busy !== 1'b1 || adpcm_rst !== 1'b1) begin
            errors++;
            $display("FAIL load_vck_ignored: din=%h busy=%b arst=%b, required din=%h busy=1 arst=1",
                     din, busy, adpcm_rst, last_nib);
        end
        play_out(20, ok);
        tick(2);
        if (!ok) return;
        n = got.size();
        bad = (n < 5);
        if (!bad) begin
            if (got[0] !== 4'hA || got[1] !== 4'hB || got[n-2] !== 4'hC || got[n-1] !== 4'hD) bad = 1'b1;
            for (int i = 2; i < n - 2; i++) if (got[i] !== 4'd0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL underrun_stream: got %0d nibbles %h %h %h .. %h %h, required A B 0.. C D",
                     n, got[0], got[1], got[2], got[n-2], got[n-1]);
        end
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_flag: got %b required 1", underrun); end
        checks++;
        if (done_cnt - d0 != 1 || fetch_q.size() != 2) begin
            errors++;
            $display("FAIL underrun_done: done=%0d fetches=%0d, required done=1 fetches=2", done_cnt - d0, fetch_q.size());
        end
        last_nib = 4'hD;
    endtask

    task automatic test_restart();
        lat = 3;
        kick(16'h0100, 16'h0110);
        for (int i = 0; i < 200 && adpcm_rst; i++) tick(1);
        for (int i = 0; i < 3; i++) begin
            vck = 1'b1;
            tick(1);
            vck = 1'b0;
            tick(11);
        end
        test_playback("restart", 16'h0200, 16'h0200, 3, 12);
    endtask

    task automatic test_random();
        logic [15:0] sa;
        for (int k = 0; k < 6; k++) begin
            sa = 16'($urandom);
            test_playback("random", sa, sa + 16'($urandom_range(0, 4)), $urandom_range(1, 4), $urandom_range(16, 30));
        end
    endtask

    task automatic test_rst_midfetch();
        int c0;
        manual = 1'b1;
        kick(16'h0400, 16'h0405);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (rom_cs !== 1'b0 || adpcm_rst !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: cs=%b arst=%b busy=%b, required cs=0 arst=1 busy=0", rom_cs, adpcm_rst, busy);
        end
        tick(2);
        rst = 1'b0;
        c0 = cs_cnt;
        tick(20);
        checks++;
        if (cs_cnt != c0 || rom_cs !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_requests: %0d cs cycles, cs=%b, required 0 and 0", cs_cnt - c0, rom_cs);
        end
        manual = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_bypass();
        test_underrun();
        test_restart();
        test_playback("wrap", 16'hFFFF, 16'h0000, 2, 24);
        test_random();
        test_rst_midfetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
